ulpi_rx_decoder: RTL
====================

ULPI_RX_DECODER -- requirements
Module: ulpi_rx_decoder

Interface
REQ-001 The block SHALL have parameter P_MAX_PKT_LEN, default 1024, maximum accepted data bytes per received packet.
REQ-002 The block SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port i_dir  input  1  ULPI dir as sampled by ulpi_ctrl.
REQ-005 The block SHALL have port i_nxt  input  1  ULPI nxt as sampled by ulpi_ctrl.
REQ-006 The block SHALL have port i_data  input  8  ULPI data bus as sampled by ulpi_ctrl.
REQ-007 The block SHALL have port o_data  output  8  received USB packet byte.
REQ-008 The block SHALL have port o_valid  output  1  o_data valid this cycle; no backpressure.
REQ-009 The block SHALL have port o_sop  output  1  beat is first byte of packet.
REQ-010 The block SHALL have port o_eop  output  1  beat is last byte of packet.
REQ-011 The block SHALL have port o_err  output  1  packet ended in error; valid only with o_eop.
REQ-012 The block SHALL have port o_linestate  output  2  last RX CMD bits [1:0].
REQ-013 The block SHALL have port o_vbus_state  output  2  last RX CMD bits [3:2].
REQ-014 The block SHALL have port o_id  output  1  last RX CMD bit 6.
REQ-015 The block SHALL have port o_rx_active  output  1  a packet is in progress.
REQ-016 The block SHALL have port o_host_disc  output  1  one-cycle pulse on RX CMD event 2'b10.

Function
REQ-017 FSM states: IDLE, TURNAROUND, RX_CMD, RX_PKT, DISCARD.
REQ-018 IDLE: i_dir=0; i_dir rising -> TURNAROUND, bus ignored that cycle.
REQ-019 Turnaround cycle with i_nxt=1 -> RX_PKT (packet start, no data byte); i_nxt=0 -> RX_CMD.
REQ-020 Any state with i_dir=0 -> IDLE next cycle; the cycle i_dir falls carries no valid bus data.
REQ-021 i_dir=1, not turnaround, i_nxt=0: i_data is an RX CMD; update o_linestate/o_vbus_state/o_id next cycle; decode event bits [5:4].
REQ-022 Event 2'b01 in RX_CMD -> RX_PKT; 2'b00 or 2'b11 in RX_PKT/DISCARD -> end packet (2'b11 sets o_err) -> RX_CMD; 2'b10 -> o_host_disc pulse, ends any packet with o_err=1.
REQ-023 i_dir=1, not turnaround, i_nxt=1 in RX_PKT: data byte; ignored in RX_CMD and DISCARD.
REQ-024 One-byte hold register: each data byte is held; held byte emitted (o_valid=1) the cycle after the next data byte arrives, or the cycle after packet end with o_eop=1.
REQ-025 o_sop SHALL accompany the first emitted beat of each packet; a 1-byte packet has o_sop=o_eop=1.
REQ-026 Zero-byte packets SHALL produce no beats and no o_eop.
REQ-027 i_dir falling in RX_PKT SHALL end the packet normally (o_err=0).
REQ-028 Byte counter width $clog2(P_MAX_PKT_LEN+1); data byte number P_MAX_PKT_LEN+1 -> emit held byte with o_eop=1,o_err=1, drop the byte, -> DISCARD until packet end (no further eop).
REQ-029 o_rx_active=1 in RX_PKT and DISCARD only, registered.
REQ-030 All outputs registered; data-to-output latency 1 cycle after the releasing event.

Reset
REQ-031 While i_rst=1: state IDLE, hold empty, counter 0, o_valid/o_sop/o_eop/o_err/o_rx_active/o_host_disc=0, o_data=8'h00, o_linestate=2'b00, o_vbus_state=2'b00, o_id=0.
REQ-032 Reset mid-packet SHALL discard held byte with no o_eop emitted; reset dominates all other inputs.

Structure
REQ-033 ulpi_pkg SHALL hold ulpi_rx_fsm_state_t (ULPI_RX_FSM_STATE_* members) and RX CMD field-position/event constants, shared with ulpi_ctrl.
REQ-034 No sub-module; single module instanced beside ulpi_ctrl, consuming its sampled bus.

Verification
REQ-035 dir 0->1 nxt=0, then RX CMD 8'h01 -> o_linestate=2'b01, o_rx_active=0, no beats.
REQ-036 Turnaround nxt=1, bytes C3,11,22, RX CMD 8'h00 -> beats C3(sop),11,22(eop,err=0), each 1 cycle after release.
REQ-037 Packet of 1 byte A5 ended by dir fall -> single beat A5, sop=eop=1, err=0.
REQ-038 RX CMD 8'h30 after 2 bytes -> second beat eop=1, err=1; 8'h20 -> o_host_disc one-cycle pulse.
REQ-039 P_MAX_PKT_LEN=4, 6 bytes -> 4 beats, 4th eop=1 err=1, bytes 5-6 dropped, o_rx_active=1 until end RX CMD.
REQ-040 i_rst=1 after 2 bytes -> next cycle all outputs at reset values, no eop; following packet decodes normally.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: RX decoder FSM states and RX CMD field layout/event codes.
package ulpi_pkg;

   typedef enum logic [2:0] {
      ULPI_RX_FSM_STATE_IDLE,
      ULPI_RX_FSM_STATE_TURNAROUND,
      ULPI_RX_FSM_STATE_RX_CMD,
      ULPI_RX_FSM_STATE_RX_PKT,
      ULPI_RX_FSM_STATE_DISCARD
   } ulpi_rx_fsm_state_t;

   localparam int ULPI_RXCMD_LINESTATE_LSB = 0;
   localparam int ULPI_RXCMD_VBUS_LSB      = 2;
   localparam int ULPI_RXCMD_EVENT_LSB     = 4;
   localparam int ULPI_RXCMD_ID_BIT        = 6;

   localparam logic [1:0] ULPI_RXCMD_EV_NONE     = 2'b00;
   localparam logic [1:0] ULPI_RXCMD_EV_RXACTIVE = 2'b01;
   localparam logic [1:0] ULPI_RXCMD_EV_HOSTDISC = 2'b10;
   localparam logic [1:0] ULPI_RXCMD_EV_RXERROR  = 2'b11;

endpackage

// File: rtl/ulpi_rx_decoder.sv
// Turns the sampled ULPI receive bus into a USB packet byte stream plus RX CMD status.
// One-byte hold delays each byte until the next byte or packet end decides its eop; no backpressure.
module ulpi_rx_decoder
   import ulpi_pkg::*;
#(
   parameter int P_MAX_PKT_LEN = 1024
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_dir,
   input  logic       i_nxt,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_sop,
   output logic       o_eop,
   output logic       o_err,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus_state,
   output logic       o_id,
   output logic       o_rx_active,
   output logic       o_host_disc
);

   localparam int               CNT_W   = $clog2(P_MAX_PKT_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_MAX_PKT_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ulpi_rx_fsm_state_t state_q, state_d;
   logic             hold_vld_q, hold_vld_d;
   logic [7:0]       hold_dat_q, hold_dat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             sop_q, sop_d;
   logic             eop_q, eop_d;
   logic             err_q, err_d;
   logic [1:0]       linestate_q, linestate_d;
   logic [1:0]       vbus_q, vbus_d;
   logic             id_q, id_d;
   logic             rx_active_q, rx_active_d;
   logic             host_disc_q, host_disc_d;

   logic       rx_cmd;
   logic [1:0] ev;
   logic       end_pkt;
   logic       end_err;
   logic       emit;

   always_comb begin
      state_d     = state_q;
      hold_vld_d  = hold_vld_q;
      hold_dat_d  = hold_dat_q;
      cnt_d       = cnt_q;
      data_d      = 8'h00;
      valid_d     = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      err_d       = 1'b0;
      linestate_d = linestate_q;
      vbus_d      = vbus_q;
      id_d        = id_q;
      host_disc_d = 1'b0;
      end_pkt     = 1'b0;
      end_err     = 1'b0;
      emit        = 1'b0;

      ev     = i_data[ULPI_RXCMD_EVENT_LSB +: 2];
      rx_cmd = i_dir && !i_nxt &&
               (state_q inside {ULPI_RX_FSM_STATE_RX_CMD, ULPI_RX_FSM_STATE_RX_PKT,
                                ULPI_RX_FSM_STATE_DISCARD});

      if (rx_cmd) begin
         linestate_d = i_data[ULPI_RXCMD_LINESTATE_LSB +: 2];
         vbus_d      = i_data[ULPI_RXCMD_VBUS_LSB +: 2];
         id_d        = i_data[ULPI_RXCMD_ID_BIT];
         host_disc_d = (ev == ULPI_RXCMD_EV_HOSTDISC);
      end

      case (state_q)
         ULPI_RX_FSM_STATE_IDLE: begin
            if (i_dir) state_d = ULPI_RX_FSM_STATE_TURNAROUND;
         end
         ULPI_RX_FSM_STATE_TURNAROUND: begin
            if (!i_dir) begin
               state_d = ULPI_RX_FSM_STATE_IDLE;
            end else if (i_nxt) begin
               state_d    = ULPI_RX_FSM_STATE_RX_PKT;
               cnt_d      = '0;
               hold_vld_d = 1'b0;
            end else begin
               state_d = ULPI_RX_FSM_STATE_RX_CMD;
            end
         end
         ULPI_RX_FSM_STATE_RX_CMD: begin
            if (!i_dir) begin
               state_d = ULPI_RX_FSM_STATE_IDLE;
            end else if (rx_cmd && ev == ULPI_RXCMD_EV_RXACTIVE) begin
               state_d    = ULPI_RX_FSM_STATE_RX_PKT;
               cnt_d      = '0;
               hold_vld_d = 1'b0;
            end
         end
         ULPI_RX_FSM_STATE_RX_PKT: begin
            if (!i_dir) begin
               end_pkt = 1'b1;
               state_d = ULPI_RX_FSM_STATE_IDLE;
            end else if (!i_nxt) begin
               // Host-disconnect and RX error both carry ev[1]; only plain 00 ends cleanly.
               if (ev != ULPI_RXCMD_EV_RXACTIVE) begin
                  end_pkt = 1'b1;
                  end_err = ev[1];
                  state_d = ULPI_RX_FSM_STATE_RX_CMD;
               end
            end else if (cnt_q == CNT_MAX) begin
               end_pkt = 1'b1;
               end_err = 1'b1;
               state_d = ULPI_RX_FSM_STATE_DISCARD;
            end else begin
               emit       = hold_vld_q;
               hold_vld_d = 1'b1;
               hold_dat_d = i_data;
               cnt_d      = cnt_q + CNT_ONE;
            end
         end
         ULPI_RX_FSM_STATE_DISCARD: begin
            if (!i_dir) begin
               state_d = ULPI_RX_FSM_STATE_IDLE;
            end else if (rx_cmd && ev != ULPI_RXCMD_EV_RXACTIVE) begin
               state_d = ULPI_RX_FSM_STATE_RX_CMD;
            end
         end
         default: state_d = ULPI_RX_FSM_STATE_IDLE;
      endcase

      if (end_pkt) begin
         emit       = hold_vld_q;
         hold_vld_d = 1'b0;
         cnt_d      = '0;
      end

      // The held byte is byte number cnt_q of the packet, so byte 1 is the sop beat.
      if (emit) begin
         valid_d = 1'b1;
         data_d  = hold_dat_q;
         sop_d   = (cnt_q == CNT_ONE);
         eop_d   = end_pkt;
         err_d   = end_pkt && end_err;
      end

      rx_active_d = (state_d == ULPI_RX_FSM_STATE_RX_PKT) ||
                    (state_d == ULPI_RX_FSM_STATE_DISCARD);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ULPI_RX_FSM_STATE_IDLE;
         hold_vld_q  <= 1'b0;
         hold_dat_q  <= 8'h00;
         cnt_q       <= '0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         err_q       <= 1'b0;
         linestate_q <= 2'b00;
         vbus_q      <= 2'b00;
         id_q        <= 1'b0;
         rx_active_q <= 1'b0;
         host_disc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_vld_q  <= hold_vld_d;
         hold_dat_q  <= hold_dat_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         err_q       <= err_d;
         linestate_q <= linestate_d;
         vbus_q      <= vbus_d;
         id_q        <= id_d;
         rx_active_q <= rx_active_d;
         host_disc_q <= host_disc_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_sop        = sop_q;
   assign o_eop        = eop_q;
   assign o_err        = err_q;
   assign o_linestate  = linestate_q;
   assign o_vbus_state = vbus_q;
   assign o_id         = id_q;
   assign o_rx_active  = rx_active_q;
   assign o_host_disc  = host_disc_q;

endmodule
